// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_pkg
// Purpose  : Shared definitions for the bus-computer sequencer. It holds the
//            instruction opcodes, the ALU op codes (also used by the ALU), the
//            sequencer state encoding, the instruction classes, and the packed
//            strobe bundle that the sequencer registers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

  // Instruction opcodes (upper IR field)
  localparam logic [3:0] c_OPC_NOP = 4'h0;
  localparam logic [3:0] c_OPC_LDA = 4'h1;
  localparam logic [3:0] c_OPC_ADD = 4'h2;
  localparam logic [3:0] c_OPC_SUB = 4'h3;
  localparam logic [3:0] c_OPC_AND = 4'h4;
  localparam logic [3:0] c_OPC_OR  = 4'h5;
  localparam logic [3:0] c_OPC_XOR = 4'h6;
  localparam logic [3:0] c_OPC_INC = 4'h7;
  localparam logic [3:0] c_OPC_DEC = 4'h8;
  localparam logic [3:0] c_OPC_NOT = 4'h9;
  localparam logic [3:0] c_OPC_OUT = 4'hE;
  localparam logic [3:0] c_OPC_HLT = 4'hF;

  // ALU op codes
  localparam int         c_ALU_OP_W = 3;
  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SUB  = 3'b001;
  localparam logic [2:0] c_ALU_DEC  = 3'b010;
  localparam logic [2:0] c_ALU_INC  = 3'b011;
  localparam logic [2:0] c_ALU_NOT  = 3'b100;
  localparam logic [2:0] c_ALU_AND  = 3'b101;
  localparam logic [2:0] c_ALU_OR   = 3'b110;
  localparam logic [2:0] c_ALU_XOR  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F_ADDR  = 4'd1,
    S_F_INSTR = 4'd2,
    S_DECODE  = 4'd3,
    S_O_ADDR  = 4'd4,
    S_O_READ  = 4'd5,
    S_A_EXEC  = 4'd6,
    S_A_WB    = 4'd7,
    S_OUTP    = 4'd8,
    S_HALT    = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_LDA   = 3'd1,
    CLS_BIN   = 3'd2,
    CLS_UNARY = 3'd3,
    CLS_OUT   = 3'd4,
    CLS_HLT   = 3'd5
  } cls_t;

  typedef struct packed {
    logic                  pc_out;
    logic                  pc_inc;
    logic                  mar_load;
    logic                  ram_out;
    logic                  ir_load;
    logic                  ir_out;
    logic                  acc_load;
    logic                  acc_out;
    logic                  breg_load;
    logic                  alu_out_en;
    logic                  out_load;
    logic                  halted;
    logic                  busy;
    logic [c_ALU_OP_W-1:0] alu_op;
  } strobe_t;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Purpose  : Control bundle between the sequencer and the datapath.
// Ports    : RUN, STEP, IR_IN          - datapath/console -> sequencer
//            PC_OUT..OUT_LOAD, ALU_OP  - sequencer strobes -> datapath
//            HALTED, BUSY              - sequencer status
//            modport master = sequencer side, slave = datapath side
// Revision : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if
  import alu_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
);
  logic                    RUN;
  logic                    STEP;
  logic [OPC_W+ADDR_W-1:0] IR_IN;
  logic                    PC_OUT;
  logic                    PC_INC;
  logic                    MAR_LOAD;
  logic                    RAM_OUT;
  logic                    IR_LOAD;
  logic                    IR_OUT;
  logic                    ACC_LOAD;
  logic                    ACC_OUT;
  logic                    BREG_LOAD;
  logic [c_ALU_OP_W-1:0]   ALU_OP;
  logic                    ALU_OUT_EN;
  logic                    OUT_LOAD;
  logic                    HALTED;
  logic                    BUSY;

  modport master (
    input  RUN, STEP, IR_IN,
    output PC_OUT, PC_INC, MAR_LOAD, RAM_OUT, IR_LOAD, IR_OUT, ACC_LOAD,
           ACC_OUT, BREG_LOAD, ALU_OP, ALU_OUT_EN, OUT_LOAD, HALTED, BUSY
  );

  modport slave (
    output RUN, STEP, IR_IN,
    input  PC_OUT, PC_INC, MAR_LOAD, RAM_OUT, IR_LOAD, IR_OUT, ACC_LOAD,
           ACC_OUT, BREG_LOAD, ALU_OP, ALU_OUT_EN, OUT_LOAD, HALTED, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_decode
// Purpose  : Combinational opcode decoder: instruction class plus ALU op.
// Ports    : i_opcode - IR opcode field
//            o_cls    - instruction class (undefined opcodes decode as NOP)
//            o_alu_op - ALU op for ALU-using classes, ADD otherwise
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_decode
  import alu_sequencer_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0]      i_opcode,
  output cls_t                  o_cls,
  output logic [c_ALU_OP_W-1:0] o_alu_op
);

  always_comb begin
    o_cls    = CLS_NOP;
    o_alu_op = c_ALU_ADD;
    case (i_opcode)
      c_OPC_LDA: o_cls = CLS_LDA;
      c_OPC_ADD: begin o_cls = CLS_BIN;   o_alu_op = c_ALU_ADD; end
      c_OPC_SUB: begin o_cls = CLS_BIN;   o_alu_op = c_ALU_SUB; end
      c_OPC_AND: begin o_cls = CLS_BIN;   o_alu_op = c_ALU_AND; end
      c_OPC_OR:  begin o_cls = CLS_BIN;   o_alu_op = c_ALU_OR;  end
      c_OPC_XOR: begin o_cls = CLS_BIN;   o_alu_op = c_ALU_XOR; end
      c_OPC_INC: begin o_cls = CLS_UNARY; o_alu_op = c_ALU_INC; end
      c_OPC_DEC: begin o_cls = CLS_UNARY; o_alu_op = c_ALU_DEC; end
      c_OPC_NOT: begin o_cls = CLS_UNARY; o_alu_op = c_ALU_NOT; end
      c_OPC_OUT: o_cls = CLS_OUT;
      c_OPC_HLT: o_cls = CLS_HLT;
      default:   o_cls = CLS_NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Fetch/decode/execute controller for the 8-bit bus computer.
//            Owns every bus-drive enable and register load strobe and the ALU
//            op code. Strobes are registered decodes of the next state, so each
//            is glitch-free and stable for the whole state.
// Ports    : CLK   - system clock, rising edge
//            RST_N - asynchronous active-low reset
//            bus   - control bundle (master side): RUN/STEP/IR_IN in,
//                    strobes, ALU_OP, HALTED, BUSY out
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  alu_sequencer_if.master bus
);

  localparam int c_IR_W = OPC_W + ADDR_W;

  state_t                r_state;
  state_t                w_state_nxt;
  state_t                w_state_end;
  strobe_t               r_strb;
  strobe_t               w_strb_nxt;
  cls_t                  w_cls;
  logic [c_ALU_OP_W-1:0] w_alu_op;
  logic [OPC_W-1:0]      w_opcode;

  assign w_opcode = bus.IR_IN[c_IR_W-1 -: OPC_W];

  alu_seq_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .i_opcode (w_opcode),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op)
  );

  // Where every instruction goes once its last state is done.
  assign w_state_end = bus.RUN ? S_F_ADDR : S_IDLE;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_strb  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_strb  <= w_strb_nxt;
    end
  end

  // Next-state logic. STEP is only looked at in IDLE, so a pulse arriving
  // mid-instruction is dropped rather than queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.RUN || bus.STEP) w_state_nxt = S_F_ADDR;
      S_F_ADDR:  w_state_nxt = S_F_INSTR;
      S_F_INSTR: w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (w_cls)
          CLS_LDA, CLS_BIN: w_state_nxt = S_O_ADDR;
          CLS_UNARY:        w_state_nxt = S_A_EXEC;
          CLS_OUT:          w_state_nxt = S_OUTP;
          CLS_HLT:          w_state_nxt = S_HALT;
          default:          w_state_nxt = w_state_end;
        endcase
      end
      S_O_ADDR:  w_state_nxt = S_O_READ;
      S_O_READ:  w_state_nxt = (w_cls == CLS_LDA) ? w_state_end : S_A_EXEC;
      S_A_EXEC:  w_state_nxt = S_A_WB;
      S_A_WB:    w_state_nxt = w_state_end;
      S_OUTP:    w_state_nxt = w_state_end;
      S_HALT:    w_state_nxt = S_HALT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Strobe decode of the state being entered.
  always_comb begin
    w_strb_nxt      = '0;
    w_strb_nxt.busy = (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALT);
    case (w_state_nxt)
      S_F_ADDR: begin
        w_strb_nxt.pc_out   = 1'b1;
        w_strb_nxt.mar_load = 1'b1;
      end
      S_F_INSTR: begin
        w_strb_nxt.ram_out = 1'b1;
        w_strb_nxt.ir_load = 1'b1;
        w_strb_nxt.pc_inc  = 1'b1;
      end
      S_O_ADDR: begin
        w_strb_nxt.ir_out   = 1'b1;
        w_strb_nxt.mar_load = 1'b1;
      end
      S_O_READ: begin
        w_strb_nxt.ram_out   = 1'b1;
        w_strb_nxt.acc_load  = (w_cls == CLS_LDA);
        w_strb_nxt.breg_load = (w_cls != CLS_LDA);
      end
      S_A_EXEC: w_strb_nxt.alu_op = w_alu_op;
      S_A_WB: begin
        // Hold the op from A_EXEC so the write-back sees the same code the
        // ALU computed with.
        w_strb_nxt.alu_op     = r_strb.alu_op;
        w_strb_nxt.alu_out_en = 1'b1;
        w_strb_nxt.acc_load   = 1'b1;
      end
      S_OUTP: begin
        w_strb_nxt.acc_out  = 1'b1;
        w_strb_nxt.out_load = 1'b1;
      end
      S_HALT:  w_strb_nxt.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.PC_OUT     = r_strb.pc_out;
  assign bus.PC_INC     = r_strb.pc_inc;
  assign bus.MAR_LOAD   = r_strb.mar_load;
  assign bus.RAM_OUT    = r_strb.ram_out;
  assign bus.IR_LOAD    = r_strb.ir_load;
  assign bus.IR_OUT     = r_strb.ir_out;
  assign bus.ACC_LOAD   = r_strb.acc_load;
  assign bus.ACC_OUT    = r_strb.acc_out;
  assign bus.BREG_LOAD  = r_strb.breg_load;
  assign bus.ALU_OP     = r_strb.alu_op;
  assign bus.ALU_OUT_EN = r_strb.alu_out_en;
  assign bus.OUT_LOAD   = r_strb.out_load;
  assign bus.HALTED     = r_strb.halted;
  assign bus.BUSY       = r_strb.busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Per-instruction expected
//            strobe sequences are queued when an instruction is launched and
//            compared cycle by cycle against the packed DUT outputs.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  // Packed observation word:
  // [15] PC_OUT [14] PC_INC [13] MAR_LOAD [12] RAM_OUT [11] IR_LOAD
  // [10] IR_OUT [9] ACC_LOAD [8] ACC_OUT [7] BREG_LOAD [6] ALU_OUT_EN
  // [5] OUT_LOAD [4] HALTED [3] BUSY [2:0] ALU_OP
  localparam logic [15:0] c_V_IDLE    = 16'h0000;
  localparam logic [15:0] c_V_FADDR   = 16'hA008;
  localparam logic [15:0] c_V_FINSTR  = 16'h5808;
  localparam logic [15:0] c_V_DECODE  = 16'h0008;
  localparam logic [15:0] c_V_OADDR   = 16'h2408;
  localparam logic [15:0] c_V_ORD_LDA = 16'h1208;
  localparam logic [15:0] c_V_ORD_B   = 16'h1088;
  localparam logic [15:0] c_V_EXEC    = 16'h0008;
  localparam logic [15:0] c_V_WB      = 16'h0248;
  localparam logic [15:0] c_V_OUTP    = 16'h0128;
  localparam logic [15:0] c_V_HALT    = 16'h0010;
  localparam logic [15:0] c_DRV_MASK  = 16'h9540;

  logic CLK = 1'b0;
  logic RST_N;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  alu_sequencer_if #(.ADDR_W(4), .OPC_W(4)) bus ();

  alu_sequencer #(
    .ADDR_W (4),
    .OPC_W  (4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  function automatic logic [15:0] sample();
    return {bus.PC_OUT, bus.PC_INC, bus.MAR_LOAD, bus.RAM_OUT, bus.IR_LOAD,
            bus.IR_OUT, bus.ACC_LOAD, bus.ACC_OUT, bus.BREG_LOAD,
            bus.ALU_OUT_EN, bus.OUT_LOAD, bus.HALTED, bus.BUSY, bus.ALU_OP};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] act,
                          input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_alu(input logic [3:0] opc);
    case (opc)
      4'h2:    return 3'b000;
      4'h3:    return 3'b001;
      4'h4:    return 3'b101;
      4'h5:    return 3'b110;
      4'h6:    return 3'b111;
      4'h7:    return 3'b011;
      4'h8:    return 3'b010;
      4'h9:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push_seq(input logic [7:0] ir);
    logic [3:0]  opc;
    logic [15:0] op;
    opc = ir[7:4];
    op  = {13'd0, ref_alu(opc)};
    exp_q.push_back(c_V_FADDR);
    exp_q.push_back(c_V_FINSTR);
    exp_q.push_back(c_V_DECODE);
    case (opc)
      4'h1: begin
        exp_q.push_back(c_V_OADDR);
        exp_q.push_back(c_V_ORD_LDA);
      end
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        exp_q.push_back(c_V_OADDR);
        exp_q.push_back(c_V_ORD_B);
        exp_q.push_back(c_V_EXEC | op);
        exp_q.push_back(c_V_WB | op);
      end
      4'h7, 4'h8, 4'h9: begin
        exp_q.push_back(c_V_EXEC | op);
        exp_q.push_back(c_V_WB | op);
      end
      4'hE:    exp_q.push_back(c_V_OUTP);
      4'hF:    exp_q.push_back(c_V_HALT);
      default: ;
    endcase
  endtask

  // Advance one cycle and compare the DUT against the head of the scoreboard.
  task automatic step_cmp(input string tag);
    logic [15:0] act;
    logic [15:0] exp;
    @(posedge CLK);
    #1;
    act = sample();
    exp = exp_q.pop_front();
    check_eq(tag, act, exp);
    check_eq("one_drv", {15'd0, ($countones(act & c_DRV_MASK) <= 1)}, 16'd1);
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(c_V_IDLE);
      step_cmp("idle");
    end
  endtask

  // Launch one instruction and follow it to its last state. IR is changed in
  // the F_ADDR cycle, well before DECODE looks at it. abort_at >= 0 pulls
  // RST_N mid-cycle after that many states and checks the async clear.
  task automatic run_instr(input logic [7:0] ir, input bit use_step,
                           input bit run_val, input bit extra_step,
                           input int abort_at);
    int n;
    push_seq(ir);
    n = exp_q.size();
    if (use_step) bus.STEP = 1'b1;
    for (int i = 0; i < n; i++) begin
      step_cmp("seq");
      if (i == 0) begin
        bus.STEP  = 1'b0;
        bus.IR_IN = ir;
        bus.RUN   = run_val;
      end
      if (extra_step) bus.STEP = (i == 2);
      if (i == abort_at) begin
        #2 RST_N = 1'b0;
        #1 check_eq("rst_async", sample(), 16'h0000);
        exp_q.delete();
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] ir;
    RST_N     = 1'b0;
    bus.RUN   = 1'b1;
    bus.STEP  = 1'b0;
    bus.IR_IN = 8'h25;
    repeat (3) @(posedge CLK);
    #1 check_eq("reset", sample(), 16'h0000);
    RST_N = 1'b1;

    // Free-running through a mix of classes
    run_instr(8'h25, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'h80, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'hB0, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'hE0, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'h13, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'h37, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'h41, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'h52, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'h63, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'h70, 1'b0, 1'b1, 1'b0, -1);
    run_instr(8'h90, 1'b0, 1'b1, 1'b0, -1);
    // RUN drops mid-instruction: the NOP completes, then IDLE
    run_instr(8'h00, 1'b0, 1'b0, 1'b0, -1);
    expect_idle(2);

    // Single step, with a stray STEP mid-instruction that must be ignored
    run_instr(8'h13, 1'b1, 1'b0, 1'b1, -1);
    expect_idle(3);
    run_instr(8'h2C, 1'b1, 1'b0, 1'b0, -1);
    expect_idle(1);

    // HLT: frozen regardless of RUN/STEP, cleared asynchronously by reset
    run_instr(8'hF0, 1'b1, 1'b0, 1'b0, -1);
    bus.RUN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.STEP = i[0];
      exp_q.push_back(c_V_HALT);
      step_cmp("halt");
    end
    bus.STEP = 1'b0;
    #2 RST_N = 1'b0;
    #1 check_eq("rst_halt", sample(), 16'h0000);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    // Random opcode stream (HLT excluded so the stream keeps going)
    for (int k = 0; k < 1800; k++) begin
      ir = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      run_instr(ir, 1'b0, 1'b1, 1'b0, -1);
    end

    // Reset in a random state of a binary instruction
    run_instr(8'h2A, 1'b0, 1'b1, 1'b0, int'($urandom_range(0, 6)));
    @(posedge CLK);
    #1 check_eq("rst_hold", sample(), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
